umi_unpack_burst: RTL and testbench

- Registered, flow-controlled UMI packet decoder; successor to the combinational unpacker.
- Accepts a header packet plus up to 15 continuation data packets over valid/ready.
- Emits one decoded beat per accepted packet, with auto-incremented destination address, beat index and first/last flags.
- Sits between a UMI link receiver and endpoint logic (memory or register targets).

---
 rtl/umi_unpack_burst.sv | 159 +++++++++++++++
 tb/tb_umi_unpack_burst.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_unpack_burst.sv
// UMI burst unpacker: decodes a header packet plus continuation data packets into addressed beats.
// Latency: one cycle from input accept to out_valid; one beat per cycle when not stalled.
// Backpressure: single output register; in_ready drops only while a held beat is refused downstream.
module umi_unpack_burst #(
    parameter int AW   = 64,
    parameter int PW   = 256,
    parameter int AINC = AW/8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    input  logic [PW-1:0] in_packet,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          cmd_write,
    output logic          cmd_read,
    output logic          cmd_signal,
    output logic          cmd_atomic_add,
    output logic          cmd_atomic_and,
    output logic          cmd_atomic_or,
    output logic          cmd_atomic_xor,
    output logic          cmd_atomic_swap,
    output logic          cmd_atomic_min,
    output logic          cmd_atomic_max,
    output logic          cmd_error,
    output logic [7:0]    cmd_opcode,
    output logic [3:0]    cmd_size,
    output logic [19:0]   cmd_user,
    output logic [AW-1:0] dstaddr,
    output logic [AW-1:0] srcaddr,
    output logic [AW-1:0] data,
    output logic [3:0]    beat,
    output logic          first,
    output logic          last,
    output logic          busy
);

    typedef enum logic {HEAD, BURST} state_t;

    localparam logic [AW-1:0] AINC_V = AW'(AINC);

    state_t        state;
    logic [10:0]   flags;
    logic [AW-1:0] dst_base;
    logic          accept;
    logic [3:0]    beat_nxt;
    logic [10:0]   in_flags;

    logic [7:0]    in_op;
    logic [3:0]    in_size;
    logic [19:0]   in_user;
    logic [AW-1:0] in_dst;
    logic [AW-1:0] in_src;
    logic [AW-1:0] in_data;

    assign in_op   = in_packet[7:0];
    assign in_size = in_packet[11:8];
    assign in_user = in_packet[31:12];
    assign in_dst  = in_packet[AW+31:32];
    assign in_src  = in_packet[2*AW+31:AW+32];
    assign in_data = in_packet[3*AW+31:2*AW+32];

    generate
        if (PW > 3*AW+32) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^in_packet[PW-1:3*AW+32];
        end
    endgenerate

    // One-hot order: write, read, signal, add, and, or, xor, swap, min, max, error
    function automatic logic [10:0] decode(input logic [7:0] op);
        logic [10:0] f;
        f = '0;
        case (op[3:0])
            4'h1: f[10] = 1'b1;
            4'h2: f[9]  = 1'b1;
            4'h3: f[8]  = 1'b1;
            4'h4: begin
                case (op[7:4])
                    4'h0:    f[7] = 1'b1;
                    4'h1:    f[6] = 1'b1;
                    4'h2:    f[5] = 1'b1;
                    4'h3:    f[4] = 1'b1;
                    4'h4:    f[3] = 1'b1;
                    4'h5:    f[2] = 1'b1;
                    4'h6:    f[1] = 1'b1;
                    default: f[0] = 1'b1;
                endcase
            end
            default: f[0] = 1'b1;
        endcase
        return f;
    endfunction

    assign in_flags = decode(in_op);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign beat_nxt = beat + 4'd1;
    assign busy     = (state == BURST);

    assign {cmd_write, cmd_read, cmd_signal, cmd_atomic_add, cmd_atomic_and,
            cmd_atomic_or, cmd_atomic_xor, cmd_atomic_swap, cmd_atomic_min,
            cmd_atomic_max, cmd_error} = flags;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= HEAD;
            out_valid  <= 1'b0;
            flags      <= '0;
            cmd_opcode <= '0;
            cmd_size   <= '0;
            cmd_user   <= '0;
            dstaddr    <= '0;
            srcaddr    <= '0;
            data       <= '0;
            dst_base   <= '0;
            beat       <= '0;
            first      <= 1'b0;
            last       <= 1'b0;
        end else begin
            if (accept)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (accept) begin
                data <= in_data;
                if (state == HEAD) begin
                    flags      <= in_flags;
                    cmd_opcode <= in_op;
                    cmd_size   <= in_size;
                    cmd_user   <= in_user;
                    srcaddr    <= in_src;
                    dstaddr    <= in_dst;
                    dst_base   <= in_dst;
                    beat       <= '0;
                    first      <= 1'b1;
                    // Only writes carry continuation packets; everything else is one beat
                    if (in_flags[10] && in_size != 4'd0) begin
                        last  <= 1'b0;
                        state <= BURST;
                    end else begin
                        last  <= 1'b1;
                    end
                end else begin
                    // Continuation: header bits ignored, address derived from latched base
                    beat    <= beat_nxt;
                    first   <= 1'b0;
                    dstaddr <= dst_base + AW'(beat_nxt) * AINC_V;
                    last    <= (beat_nxt == cmd_size);
                    if (beat_nxt == cmd_size)
                        state <= HEAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_umi_unpack_burst.sv
// Directed bench for umi_unpack_burst: expected beats are queued when driven and compared as they emerge.
module tb_umi_unpack_burst;
    localparam int AW = 64;
    localparam int PW = 256;

    localparam logic [10:0] F_WR  = 11'h400;
    localparam logic [10:0] F_RD  = 11'h200;
    localparam logic [10:0] F_SIG = 11'h100;
    localparam logic [10:0] F_ADD = 11'h080;
    localparam logic [10:0] F_XOR = 11'h010;
    localparam logic [10:0] F_MIN = 11'h004;
    localparam logic [10:0] F_ERR = 11'h001;

    typedef struct packed {
        logic [10:0]   flags;
        logic [7:0]    op;
        logic [3:0]    size;
        logic [19:0]   user;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [AW-1:0] data;
        logic [3:0]    beat;
        logic          first;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          in_valid;
    logic [PW-1:0] in_packet;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          cmd_write, cmd_read, cmd_signal;
    logic          cmd_atomic_add, cmd_atomic_and, cmd_atomic_or, cmd_atomic_xor;
    logic          cmd_atomic_swap, cmd_atomic_min, cmd_atomic_max, cmd_error;
    logic [7:0]    cmd_opcode;
    logic [3:0]    cmd_size;
    logic [19:0]   cmd_user;
    logic [AW-1:0] dstaddr, srcaddr, data;
    logic [3:0]    beat;
    logic          first, last, busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    umi_unpack_burst #(.AW(AW), .PW(PW), .AINC(AW/8)) dut (
        .clk(clk), .nreset(nreset),
        .in_valid(in_valid), .in_packet(in_packet), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .cmd_write(cmd_write), .cmd_read(cmd_read), .cmd_signal(cmd_signal),
        .cmd_atomic_add(cmd_atomic_add), .cmd_atomic_and(cmd_atomic_and),
        .cmd_atomic_or(cmd_atomic_or), .cmd_atomic_xor(cmd_atomic_xor),
        .cmd_atomic_swap(cmd_atomic_swap), .cmd_atomic_min(cmd_atomic_min),
        .cmd_atomic_max(cmd_atomic_max), .cmd_error(cmd_error),
        .cmd_opcode(cmd_opcode), .cmd_size(cmd_size), .cmd_user(cmd_user),
        .dstaddr(dstaddr), .srcaddr(srcaddr), .data(data),
        .beat(beat), .first(first), .last(last), .busy(busy)
    );

    function automatic exp_t observe();
        exp_t o;
        o.flags = {cmd_write, cmd_read, cmd_signal, cmd_atomic_add, cmd_atomic_and,
                   cmd_atomic_or, cmd_atomic_xor, cmd_atomic_swap, cmd_atomic_min,
                   cmd_atomic_max, cmd_error};
        o.op = cmd_opcode;  o.size = cmd_size;  o.user = cmd_user;
        o.dst = dstaddr;    o.src = srcaddr;    o.data = data;
        o.beat = beat;      o.first = first;    o.last = last;
        return o;
    endfunction

    function automatic exp_t mke(input logic [10:0] f, input logic [7:0] op, input logic [3:0] sz,
                                 input logic [19:0] usr, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                                 input logic [AW-1:0] dat, input logic [3:0] bt, input logic fst, input logic lst);
        exp_t e;
        e.flags = f;  e.op = op;  e.size = sz;  e.user = usr;
        e.dst = dst;  e.src = src;  e.data = dat;
        e.beat = bt;  e.first = fst;  e.last = lst;
        return e;
    endfunction

    function automatic logic [PW-1:0] mk(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] usr,
                                         input logic [AW-1:0] dst, input logic [AW-1:0] src, input logic [AW-1:0] dat);
        logic [PW-1:0] p;
        p = '0;
        p[7:0] = op;  p[11:8] = sz;  p[31:12] = usr;
        p[AW+31:32] = dst;
        p[2*AW+31:AW+32] = src;
        p[3*AW+31:2*AW+32] = dat;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [PW-1:0] p);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_packet = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 256'(q.size()), 256'(0));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (nreset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                e = q.pop_front();
                chk("beat", 256'(observe()), 256'(e));
                chk("onehot", 256'($countones(observe().flags)), 256'(1));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0]  ops [5];
        logic [10:0] fls [5];
        exp_t        e0;
        int          c0;

        nreset = 1'b0;  in_valid = 1'b0;  in_packet = '0;  out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_outputs", 256'(observe()), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk); #1;
        nreset = 1'b1;

        // Single write
        q.push_back(mke(F_WR, 8'h01, 4'h0, 20'h00012, 64'h1000, 64'h5000, 64'hAA, 4'd0, 1'b1, 1'b1));
        send(mk(8'h01, 4'h0, 20'h00012, 64'h1000, 64'h5000, 64'hAA));
        chk("single_latency", 256'(out_valid), 256'(1));
        drain();

        // Four-beat write burst with garbage continuation headers
        q.push_back(mke(F_WR, 8'h01, 4'h3, 20'hABCDE, 64'h2000, 64'h7000, 64'h11, 4'd0, 1'b1, 1'b0));
        q.push_back(mke(F_WR, 8'h01, 4'h3, 20'hABCDE, 64'h2008, 64'h7000, 64'h22, 4'd1, 1'b0, 1'b0));
        q.push_back(mke(F_WR, 8'h01, 4'h3, 20'hABCDE, 64'h2010, 64'h7000, 64'h33, 4'd2, 1'b0, 1'b0));
        q.push_back(mke(F_WR, 8'h01, 4'h3, 20'hABCDE, 64'h2018, 64'h7000, 64'h44, 4'd3, 1'b0, 1'b1));
        c0 = cyc;
        send(mk(8'h01, 4'h3, 20'hABCDE, 64'h2000, 64'h7000, 64'h11));
        chk("burst_busy_set", 256'(busy), 256'(1));
        send(mk(8'hFF, 4'hC, 20'hFFFFF, 64'hDEAD, 64'hBEEF, 64'h22));
        send(mk(8'h02, 4'h0, 20'h00000, 64'h0, 64'h0, 64'h33));
        chk("burst_busy_mid", 256'(busy), 256'(1));
        send(mk(8'h34, 4'h7, 20'h12345, 64'hFFFF, 64'h1, 64'h44));
        chk("burst_busy_clr", 256'(busy), 256'(0));
        chk("burst_throughput", 256'(cyc - c0), 256'(4));
        drain();

        // Read with nonzero size stays single-beat
        q.push_back(mke(F_RD, 8'h02, 4'h7, 20'h00001, 64'h3000, 64'h8000, 64'h0, 4'd0, 1'b1, 1'b1));
        send(mk(8'h02, 4'h7, 20'h00001, 64'h3000, 64'h8000, 64'h0));
        chk("read_no_busy", 256'(busy), 256'(0));
        drain();

        // Atomic / signal / error decode, back to back
        ops = '{8'h54, 8'h74, 8'h0F, 8'h04, 8'h03};
        fls = '{F_MIN, F_ERR, F_ERR, F_ADD, F_SIG};
        for (int i = 0; i < 5; i++) begin
            q.push_back(mke(fls[i], ops[i], 4'h2, 20'(i), 64'(i) * 64'h100, 64'h9, 64'(i) + 64'h50, 4'd0, 1'b1, 1'b1));
            send(mk(ops[i], 4'h2, 20'(i), 64'(i) * 64'h100, 64'h9, 64'(i) + 64'h50));
        end
        chk("decode_no_busy", 256'(busy), 256'(0));
        drain();

        // Backpressure during a two-beat burst
        out_ready = 1'b0;
        e0 = mke(F_WR, 8'h01, 4'h1, 20'h00003, 64'h9000, 64'hA000, 64'h55, 4'd0, 1'b1, 1'b0);
        q.push_back(e0);
        q.push_back(mke(F_WR, 8'h01, 4'h1, 20'h00003, 64'h9008, 64'hA000, 64'h66, 4'd1, 1'b0, 1'b1));
        send(mk(8'h01, 4'h1, 20'h00003, 64'h9000, 64'hA000, 64'h55));
        in_valid  = 1'b1;
        in_packet = mk(8'h13, 4'hF, 20'h77777, 64'h1234, 64'h5678, 64'h66);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 256'(in_ready), 256'(0));
            chk("stall_hold", 256'(observe()), 256'(e0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("resume_valid", 256'(out_valid), 256'(1));
        chk("resume_beat", 256'(beat), 256'(1));
        drain();

        // Address wrap at the top of the address space
        q.push_back(mke(F_WR, 8'h01, 4'h1, 20'h00004, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 64'h77, 4'd0, 1'b1, 1'b0));
        q.push_back(mke(F_WR, 8'h01, 4'h1, 20'h00004, 64'h0, 64'h1, 64'h88, 4'd1, 1'b0, 1'b1));
        send(mk(8'h01, 4'h1, 20'h00004, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 64'h77));
        send(mk(8'h01, 4'h1, 20'h00004, 64'h0, 64'h0, 64'h88));
        drain();

        // Reset mid-burst discards the partial burst
        q.push_back(mke(F_WR, 8'h01, 4'h3, 20'h00006, 64'h4000, 64'h2, 64'h99, 4'd0, 1'b1, 1'b0));
        send(mk(8'h01, 4'h3, 20'h00006, 64'h4000, 64'h2, 64'h99));
        send(mk(8'h00, 4'h0, 20'h00000, 64'h0, 64'h0, 64'h9A));
        chk("pre_rst_busy", 256'(busy), 256'(1));
        chk("pre_rst_beat", 256'(beat), 256'(1));
        nreset = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_outputs", 256'(observe()), 256'(0));
        @(posedge clk); #1;
        nreset = 1'b1;
        q.push_back(mke(F_WR, 8'h01, 4'h0, 20'h00005, 64'h5000, 64'h3, 64'hBB, 4'd0, 1'b1, 1'b1));
        send(mk(8'h01, 4'h0, 20'h00005, 64'h5000, 64'h3, 64'hBB));
        chk("post_rst_busy", 256'(busy), 256'(0));
        drain();

        chk("queue_empty", 256'(q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
